// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator entry FSM.
// The optional multiplier is enabled by defining CALC_MULT_EN.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_A   = 2'd0,
    ST_OP  = 2'd1,
    ST_B   = 2'd2,
    ST_RES = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_MULT = 3'd2,
    OP_AND  = 3'd3,
    OP_SUB  = 3'd4,
    OP_OR   = 3'd5
  } op_e;

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MULT = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;

  function automatic logic is_op_key(input logic [4:0] key);
    return key inside {KEY_ADD, KEY_MULT, KEY_AND, KEY_SUB, KEY_OR};
  endfunction

  function automatic op_e key_to_op(input logic [4:0] key);
    case (key)
      KEY_ADD:  return OP_ADD;
      KEY_MULT: return OP_MULT;
      KEY_AND:  return OP_AND;
      KEY_SUB:  return OP_SUB;
      KEY_OR:   return OP_OR;
      default:  return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the calculator; results wrap modulo 2^WIDTH.
// The multiply path exists only when CALC_MULT_EN is defined.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_c_o,
  output logic             ovf_c_o,
  output logic             neg_c_o
);

  logic [WIDTH:0] sum_c;
  assign sum_c = {1'b0, a_i} + {1'b0, b_i};

`ifdef CALC_MULT_EN
  logic [2*WIDTH-1:0] prod_c;
  assign prod_c = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
`endif

  always_comb begin
    res_c_o = '0;
    ovf_c_o = 1'b0;
    neg_c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_c_o = sum_c[WIDTH-1:0];
        ovf_c_o = sum_c[WIDTH];
      end
      OP_SUB: begin
        res_c_o = a_i - b_i;
        neg_c_o = (b_i > a_i);
      end
      OP_AND: res_c_o = a_i & b_i;
      OP_OR:  res_c_o = a_i | b_i;
`ifdef CALC_MULT_EN
      OP_MULT: begin
        res_c_o = prod_c[WIDTH-1:0];
        ovf_c_o = |prod_c[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Key-entry state machine for a two-operand calculator (A op B = result).
// Define CALC_MULT_EN to accept the MULT key; otherwise it is rejected.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_val,
  input  logic             dec_mode,
  output logic             restriction,
  output logic [WIDTH-1:0] disp_val,
  output logic [2:0]       op_code,
  output logic             result_valid,
  output logic             flag_ovf,
  output logic             flag_neg,
  output logic             key_err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, disp_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic             dec_q, ovf_q, neg_q, rv_q, err_q;

  logic             is_digit_c, bad_c, clr_c, a_full_c, b_full_c;
  logic [3:0]       digit_c;
  logic [WIDTH-1:0] dig_ext_c, a_app_c, b_app_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c, alu_neg_c;

  assign is_digit_c = ~key_val[4];
  assign digit_c    = key_val[3:0];
  assign dig_ext_c  = WIDTH'(digit_c);
  assign a_full_c   = (cnt_a_q == CNT_W'(MAX_DIGITS));
  assign b_full_c   = (cnt_b_q == CNT_W'(MAX_DIGITS));

  // Shift-in of the new digit: x*10 = (x<<3)+(x<<1) in decimal, x*16 in hex
  assign a_app_c = dec_q ? (a_q << 3) + (a_q << 1) + dig_ext_c : (a_q << 4) | dig_ext_c;
  assign b_app_c = dec_q ? (b_q << 3) + (b_q << 1) + dig_ext_c : (b_q << 4) | dig_ext_c;

  // Keys rejected outright with a key_err pulse
  always_comb begin
    bad_c = (key_val > KEY_CLR) || (dec_q && is_digit_c && (digit_c > 4'd9));
`ifndef CALC_MULT_EN
    bad_c = bad_c || (key_val == KEY_MULT);
`endif
  end

  // A decimal/hex switch clears everything and outranks any key in that cycle
  assign clr_c = (dec_mode != dec_q) ||
                 (key_valid && ((key_val == KEY_CLR) ||
                                ((key_val == KEY_CE) && (state_q == ST_RES))));

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_c_o (alu_res_c),
    .ovf_c_o (alu_ovf_c),
    .neg_c_o (alu_neg_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_A;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      dec_q   <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dec_q <= dec_mode;
      rv_q  <= 1'b0;
      err_q <= 1'b0;
      if (clr_c) begin
        state_q <= ST_A;
        op_q    <= OP_NONE;
        a_q     <= '0;
        b_q     <= '0;
        res_q   <= '0;
        disp_q  <= '0;
        cnt_a_q <= '0;
        cnt_b_q <= '0;
        ovf_q   <= 1'b0;
        neg_q   <= 1'b0;
      end else if (key_valid) begin
        if (bad_c) begin
          err_q <= 1'b1;
        end else if (is_digit_c) begin
          case (state_q)
            ST_A: begin
              if (a_full_c) begin
                err_q <= 1'b1;
              end else begin
                a_q     <= a_app_c;
                cnt_a_q <= cnt_a_q + CNT_W'(1);
                disp_q  <= a_app_c;
              end
            end
            ST_OP: begin
              b_q     <= dig_ext_c;
              cnt_b_q <= CNT_W'(1);
              disp_q  <= dig_ext_c;
              state_q <= ST_B;
            end
            ST_B: begin
              if (b_full_c) begin
                err_q <= 1'b1;
              end else begin
                b_q     <= b_app_c;
                cnt_b_q <= cnt_b_q + CNT_W'(1);
                disp_q  <= b_app_c;
              end
            end
            default: begin
              a_q     <= dig_ext_c;
              cnt_a_q <= CNT_W'(1);
              disp_q  <= dig_ext_c;
              state_q <= ST_A;
            end
          endcase
        end else if (is_op_key(key_val)) begin
          case (state_q)
            ST_A, ST_OP: begin
              op_q    <= key_to_op(key_val);
              state_q <= ST_OP;
            end
            ST_RES: begin
              a_q     <= res_q;
              cnt_a_q <= '0;
              op_q    <= key_to_op(key_val);
              state_q <= ST_OP;
            end
            default: ;
          endcase
        end else if (key_val == KEY_EXE) begin
          if (state_q == ST_B) begin
            res_q   <= alu_res_c;
            disp_q  <= alu_res_c;
            ovf_q   <= alu_ovf_c;
            neg_q   <= alu_neg_c;
            rv_q    <= 1'b1;
            state_q <= ST_RES;
          end
        end else if (key_val == KEY_CE) begin
          case (state_q)
            ST_A: begin
              a_q     <= '0;
              cnt_a_q <= '0;
              disp_q  <= '0;
            end
            ST_B: begin
              b_q     <= '0;
              cnt_b_q <= '0;
              disp_q  <= a_q;
              state_q <= ST_OP;
            end
            ST_OP: begin
              op_q    <= OP_NONE;
              state_q <= ST_A;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign restriction  = dec_q;
  assign disp_val     = disp_q;
  assign op_code      = op_q;
  assign result_valid = rv_q;
  assign flag_ovf     = ovf_q;
  assign flag_neg     = neg_q;
  assign key_err      = err_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Vector-table bench for calc_entry_fsm with a queue scoreboard.
// Expectations follow CALC_MULT_EN the same way the design does.
module tb_calc_entry_fsm;
  import calc_pkg::*;

  typedef struct {
    logic        r;
    logic        d;
    logic        kv;
    logic [4:0]  k;
    logic [15:0] disp;
    logic [2:0]  op;
    logic        rv;
    logic        err;
    logic        chkf;
    logic        ovf;
    logic        neg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, key_valid, dec_mode;
  logic [4:0]  key_val;
  logic        restriction, result_valid, flag_ovf, flag_neg, key_err;
  logic [15:0] disp_val;
  logic [2:0]  op_code;

  vec_t sb[$];
  vec_t tbl[$];
  vec_t chk_e;
  logic exp_restr;
  logic bad;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_val      (key_val),
    .dec_mode     (dec_mode),
    .restriction  (restriction),
    .disp_val     (disp_val),
    .op_code      (op_code),
    .result_valid (result_valid),
    .flag_ovf     (flag_ovf),
    .flag_neg     (flag_neg),
    .key_err      (key_err)
  );

  function automatic vec_t mk(logic r, logic d, logic kv, logic [4:0] k, logic [15:0] disp,
                              logic [2:0] op, logic rv, logic err, logic chkf, logic ovf, logic neg);
    vec_t v;
    v.r = r; v.d = d; v.kv = kv; v.k = k; v.disp = disp; v.op = op;
    v.rv = rv; v.err = err; v.chkf = chkf; v.ovf = ovf; v.neg = neg;
    return v;
  endfunction

  function automatic vec_t kv_v(logic d, logic [4:0] k, logic [15:0] disp, logic [2:0] op, logic err);
    return mk(1'b0, d, 1'b1, k, disp, op, 1'b0, err, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t idle_v(logic d, logic [15:0] disp, logic [2:0] op);
    return mk(1'b0, d, 1'b0, 5'h00, disp, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t fl_v(logic r, logic d, logic kv, logic [4:0] k, logic [15:0] disp,
                                logic [2:0] op, logic rv, logic ovf, logic neg);
    return mk(r, d, kv, k, disp, op, rv, 1'b0, 1'b1, ovf, neg);
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    rst       = v.r;
    dec_mode  = v.d;
    key_valid = v.kv;
    key_val   = v.k;
    sb.push_back(v);
  endtask

  // Each driven cycle is checked just after the following rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      chk_e = sb.pop_front();
      vectors++;
      exp_restr = chk_e.r ? 1'b0 : chk_e.d;
      bad = (disp_val !== chk_e.disp) || (op_code !== chk_e.op) ||
            (result_valid !== chk_e.rv) || (key_err !== chk_e.err) ||
            (restriction !== exp_restr) ||
            (chk_e.chkf && ((flag_ovf !== chk_e.ovf) || (flag_neg !== chk_e.neg)));
      if (bad) begin
        miscompares++;
        $display("FAIL vec%0d key=%h kv=%b: got disp=%h op=%0d rv=%b err=%b ovf=%b neg=%b restr=%b; want disp=%h op=%0d rv=%b err=%b ovf=%b neg=%b (flags checked=%b) restr=%b",
                 vectors, chk_e.k, chk_e.kv, disp_val, op_code, result_valid, key_err,
                 flag_ovf, flag_neg, restriction, chk_e.disp, chk_e.op, chk_e.rv, chk_e.err,
                 chk_e.ovf, chk_e.neg, chk_e.chkf, exp_restr);
      end
    end
  end

  initial begin
    rst = 1'b1; dec_mode = 1'b0; key_valid = 1'b0; key_val = 5'h00;

    // Hex mode basics
    tbl.push_back(fl_v(1'b1, 1'b0, 1'b0, 5'h00, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h01, 16'h0001, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h02, 16'h0012, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_ADD, 16'h0012, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h03, 16'h0003, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'h0015, OP_ADD, 1'b1, 1'b0, 1'b0));
    tbl.push_back(idle_v(1'b0, 16'h0015, OP_ADD));
    tbl.push_back(kv_v(1'b0, KEY_EXE, 16'h0015, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_CLR, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));
    // Digit limit
    tbl.push_back(kv_v(1'b0, 5'h01, 16'h0001, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h02, 16'h0012, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h03, 16'h0123, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h04, 16'h1234, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h05, 16'h1234, OP_NONE, 1'b1));
    tbl.push_back(idle_v(1'b0, 16'h1234, OP_NONE));
    tbl.push_back(kv_v(1'b0, KEY_CE, 16'h0000, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_EXE, 16'h0000, OP_NONE, 1'b0));
    // ADD carry-out
    tbl.push_back(kv_v(1'b0, 5'h0F, 16'h000F, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h0F, 16'h00FF, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h0F, 16'h0FFF, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h0F, 16'hFFFF, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_ADD, 16'hFFFF, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h01, 16'h0001, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'h0000, OP_ADD, 1'b1, 1'b1, 1'b0));
    // Chain from result with OR, which clears flags
    tbl.push_back(kv_v(1'b0, KEY_OR, 16'h0000, OP_OR, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h05, 16'h0005, OP_OR, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'h0005, OP_OR, 1'b1, 1'b0, 1'b0));
    // Digit from RES, operator replace, CE in OP/B, operator in B ignored
    tbl.push_back(kv_v(1'b0, 5'h07, 16'h0007, OP_OR, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_AND, 16'h0007, OP_AND, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_SUB, 16'h0007, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_CE, 16'h0007, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h02, 16'h0072, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_SUB, 16'h0072, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h08, 16'h0008, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_ADD, 16'h0008, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_CE, 16'h0072, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h03, 16'h0003, OP_SUB, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'h006F, OP_SUB, 1'b1, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h18, 16'h006F, OP_SUB, 1'b1));
    // MULT then chained ADD
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_CLR, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h09, 16'h0009, OP_NONE, 1'b0));
`ifdef CALC_MULT_EN
    tbl.push_back(kv_v(1'b0, KEY_MULT, 16'h0009, OP_MULT, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h03, 16'h0003, OP_MULT, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'd27, OP_MULT, 1'b1, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_ADD, 16'd27, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h01, 16'h0001, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'd28, OP_ADD, 1'b1, 1'b0, 1'b0));
`else
    tbl.push_back(kv_v(1'b0, KEY_MULT, 16'h0009, OP_NONE, 1'b1));
    tbl.push_back(kv_v(1'b0, 5'h03, 16'h0093, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_EXE, 16'h0093, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b0, KEY_ADD, 16'h0093, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b0, 5'h01, 16'h0001, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b0, 1'b1, KEY_EXE, 16'h0094, OP_ADD, 1'b1, 1'b0, 1'b0));
`endif
    // Decimal mode: switching clears, then 5 - 7
    tbl.push_back(fl_v(1'b0, 1'b1, 1'b0, 5'h00, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h05, 16'h0005, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b1, KEY_SUB, 16'h0005, OP_SUB, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h07, 16'h0007, OP_SUB, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b1, 1'b1, KEY_EXE, 16'hFFFE, OP_SUB, 1'b1, 1'b0, 1'b1));
    // Decimal entry, rejected hex digit, CE in B returns to OP
    tbl.push_back(kv_v(1'b1, KEY_CLR, 16'h0000, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h01, 16'h0001, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h02, 16'h000C, OP_NONE, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h0B, 16'h000C, OP_NONE, 1'b1));
    tbl.push_back(idle_v(1'b1, 16'h000C, OP_NONE));
    tbl.push_back(kv_v(1'b1, KEY_ADD, 16'h000C, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h04, 16'h0004, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b1, KEY_CE, 16'h000C, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b1, KEY_EXE, 16'h000C, OP_ADD, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h06, 16'h0006, OP_ADD, 1'b0));
    tbl.push_back(fl_v(1'b0, 1'b1, 1'b1, KEY_EXE, 16'h0012, OP_ADD, 1'b1, 1'b0, 1'b0));
    tbl.push_back(kv_v(1'b1, 5'h1F, 16'h0012, OP_ADD, 1'b1));

    foreach (tbl[i]) step(tbl[i]);

    // Mode switch with a simultaneous key: the clear wins
    step(kv_v(1'b0, 5'h03, 16'h0000, OP_NONE, 1'b0));
    // Held key_valid counts once per cycle, up to the digit limit
    step(kv_v(1'b0, 5'h03, 16'h0003, OP_NONE, 1'b0));
    step(kv_v(1'b0, 5'h03, 16'h0033, OP_NONE, 1'b0));
    step(kv_v(1'b0, 5'h03, 16'h0333, OP_NONE, 1'b0));
    step(kv_v(1'b0, 5'h03, 16'h3333, OP_NONE, 1'b0));
    step(kv_v(1'b0, 5'h03, 16'h3333, OP_NONE, 1'b1));
    // Reset during B entry drops the concurrent key
    step(kv_v(1'b0, KEY_CLR, 16'h0000, OP_NONE, 1'b0));
    step(kv_v(1'b0, 5'h01, 16'h0001, OP_NONE, 1'b0));
    step(kv_v(1'b0, KEY_ADD, 16'h0001, OP_ADD, 1'b0));
    step(kv_v(1'b0, 5'h02, 16'h0002, OP_ADD, 1'b0));
    step(fl_v(1'b1, 1'b0, 1'b1, 5'h07, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));
    step(fl_v(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000, OP_NONE, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; key_val = 5'h00;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
